cus19_dmem_access_unit: RTL and testbench
=========================================

Name: cus19_dmem_access_unit

Overview:
- Memory-stage controller between execute and the load unit.
- Accepts one load/store request from execute over a valid/ready handshake.
- Runs a req/ack transaction against the byte-wide data memory, which has variable latency.
- For loads, presents the returned byte and a one-cycle register-write strobe to the load unit, which zero-extends the byte to 16 bits.
- Includes a wait-cycle watchdog that aborts transactions the memory never acknowledges.

Parameters:
- ADDR_W, 8: data-memory byte-address width.
- REG_IDX_W, 3: destination register index width.
- TIMEOUT, 15: maximum cycles dm_req_out is held without ack before abort. 0 disables the watchdog.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- ex_valid_in  input  1  execute presents a memory request.
- ex_ready_out  output  1  unit can accept a request this cycle.
- ex_is_load_in  input  1  1 = load, 0 = store.
- ex_addr_in  input  ADDR_W  byte address.
- ex_wr_data_in  input  8  store data.
- ex_rd_idx_in  input  REG_IDX_W  load destination register.
- dm_req_out  output  1  memory request.
- dm_we_out  output  1  memory write enable.
- dm_addr_out  output  ADDR_W  memory address.
- dm_wr_data_out  output  8  memory write data.
- dm_ack_in  input  1  memory completion.
- dm_rd_data_in  input  8  memory read data, valid with dm_ack_in on loads.
- dm_rd_data_out  output  8  captured load byte, to the load unit.
- reg_wr_out  output  1  load-complete strobe, to the load unit's reg_wr_in.
- rd_idx_out  output  REG_IDX_W  destination register of the completed load.
- busy_out  output  1  transaction in flight; pipeline stall.
- timeout_err_out  output  1  sticky watchdog error.

Behaviour:
- Reset (asynchronous, effective immediately):
  - State goes to IDLE.
  - Every registered output clears to 0.
  - ex_ready_out is 0 while rst_in is high.
- States: IDLE, REQ, DONE.
- IDLE:
  - ex_ready_out = 1 (combinational from state); busy_out = 0.
  - On a rising edge with ex_valid_in=1, latch is_load, addr, wr_data and rd_idx, then go to REQ.
- REQ:
  - dm_req_out = 1, dm_we_out = ~is_load, dm_addr_out = latched address, dm_wr_data_out = latched data. All four stay stable until the transaction ends.
  - ex_ready_out = 0; busy_out = 1.
  - Wait counter clears on entry and increments each cycle without ack.
  - Edge with dm_ack_in=1: capture dm_rd_data_in if the request is a load, then go to DONE.
  - Edge with the counter equal to TIMEOUT-1 and no ack (TIMEOUT>0): set timeout_err_out, go to IDLE, no register write.
  - Ack and timeout on the same edge: ack wins.
- DONE:
  - dm_req_out = 0; busy_out = 1.
  - Load: reg_wr_out = 1 for exactly this cycle; dm_rd_data_out and rd_idx_out show the captured values.
  - Store: reg_wr_out stays 0.
  - Always returns to IDLE next edge.
- dm_rd_data_out and rd_idx_out hold their last values until the next load completes. They do not update on stores.
- dm_ack_in is ignored outside REQ.
- ex_valid_in is ignored while not IDLE. Upstream must hold its request until ready.
- timeout_err_out clears only on reset.
- Latency:
  - Accept on edge 0: dm_req_out high from cycle 1.
  - Ack sampled on edge k: reg_wr_out high in cycle k+1; ready again in cycle k+2.
  - Minimum of 3 cycles between consecutive accepts.
- Reset during REQ or DONE: dm_req_out and reg_wr_out drop immediately and no write is issued.
- Counter width is sized for TIMEOUT. No wrap is possible, because a timeout exits REQ first.

Test Plan:
- Load with immediate ack:
  - Stimulus: addr 0x10, rd 3; memory acks on the first REQ cycle with 0xA5.
  - Required: dm_req_out high for 1 cycle, dm_we_out=0; reg_wr_out pulses 1 cycle with dm_rd_data_out=0xA5, rd_idx_out=3; ex_ready_out back 2 cycles after ack.
- Store with 3-cycle ack delay:
  - Stimulus: addr 0x22, data 0x3C.
  - Required: dm_req_out/dm_we_out high 4 cycles with addr 0x22, data 0x3C stable; reg_wr_out stays 0; dm_rd_data_out keeps the prior 0xA5.
- Watchdog:
  - Stimulus: TIMEOUT=4, memory never acks.
  - Required: dm_req_out high exactly 4 cycles then 0; timeout_err_out=1 and stays 1; no reg_wr_out; the next request is accepted.
- Ack on the final watchdog cycle:
  - Stimulus: TIMEOUT=4, load acked with 0x5A on the 4th REQ cycle.
  - Required: load completes, reg_wr_out pulses with 0x5A; timeout_err_out stays 0.
- Back-pressure:
  - Stimulus: ex_valid_in held high with a new request during an in-flight load.
  - Required: ex_ready_out=0 until IDLE; the second request is accepted exactly once; stray dm_ack_in pulses in IDLE cause no action.
- Reset mid-REQ:
  - Stimulus: assert rst_in asynchronously while dm_req_out=1.
  - Required: dm_req_out, reg_wr_out, busy_out and dm_rd_data_out go to 0 without waiting for a clock edge; after release the unit is in IDLE with ex_ready_out=1.

Source files
------------

// File: rtl/cus19_dmem_access_unit.sv
// Memory-stage controller: accepts one load/store from execute and runs a
// req/ack transaction on the byte-wide data memory, with a wait-cycle watchdog.
module cus19_dmem_access_unit #(
  parameter int ADDR_W    = 8,
  parameter int REG_IDX_W = 3,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 ex_valid_in,
  output logic                 ex_ready_out,
  input  logic                 ex_is_load_in,
  input  logic [ADDR_W-1:0]    ex_addr_in,
  input  logic [7:0]           ex_wr_data_in,
  input  logic [REG_IDX_W-1:0] ex_rd_idx_in,
  output logic                 dm_req_out,
  output logic                 dm_we_out,
  output logic [ADDR_W-1:0]    dm_addr_out,
  output logic [7:0]           dm_wr_data_out,
  input  logic                 dm_ack_in,
  input  logic [7:0]           dm_rd_data_in,
  output logic [7:0]           dm_rd_data_out,
  output logic                 reg_wr_out,
  output logic [REG_IDX_W-1:0] rd_idx_out,
  output logic                 busy_out,
  output logic                 timeout_err_out
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t               state, state_nxt;
  logic                 is_load;
  logic [REG_IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0]     cnt;
  logic                 expire;

  // Ack has priority over the watchdog on the same edge.
  assign expire = (TIMEOUT > 0) && (state == REQ) && !dm_ack_in && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ex_valid_in) state_nxt = REQ;
      REQ:     if (dm_ack_in) state_nxt = DONE;
               else if (expire) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake strobes decode straight from state so reset removes them at once.
  always_comb begin
    ex_ready_out = (state == IDLE) && !rst_in;
    busy_out     = (state != IDLE);
    dm_req_out   = (state == REQ);
    dm_we_out    = (state == REQ) && !is_load;
    reg_wr_out   = (state == DONE) && is_load;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      is_load         <= 1'b0;
      rd_idx          <= '0;
      cnt             <= '0;
      dm_addr_out     <= '0;
      dm_wr_data_out  <= '0;
      dm_rd_data_out  <= '0;
      rd_idx_out      <= '0;
      timeout_err_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && ex_valid_in) begin
        is_load        <= ex_is_load_in;
        dm_addr_out    <= ex_addr_in;
        dm_wr_data_out <= ex_wr_data_in;
        rd_idx         <= ex_rd_idx_in;
      end
      if (state != REQ)
        cnt <= '0;
      else if (!dm_ack_in)
        cnt <= cnt + 1'b1;
      if (state == REQ && dm_ack_in && is_load) begin
        dm_rd_data_out <= dm_rd_data_in;
        rd_idx_out     <= rd_idx;
      end
      if (expire)
        timeout_err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cus19_dmem_access_unit.sv
// Randomized self-checking bench for cus19_dmem_access_unit against a
// transaction-level model of the req/ack and watchdog rules.
module tb_cus19_dmem_access_unit;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid, ex_is_load;
  logic [7:0] ex_addr, ex_wr_data;
  logic [2:0] ex_rd_idx;
  logic       dm_ack;
  logic [7:0] dm_rd_data;
  logic       ex_ready, dm_req, dm_we, reg_wr, busy, timeout_err;
  logic [7:0] dm_addr, dm_wr_data, dm_rd_data_q;
  logic [2:0] rd_idx_q;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [7:0] exp_rd_data = 8'h00;
  logic [2:0] exp_rd_idx  = 3'd0;
  logic       exp_err     = 1'b0;

  cus19_dmem_access_unit #(.ADDR_W(8), .REG_IDX_W(3), .TIMEOUT(TO)) dut (
    .clk_in(clk), .rst_in(rst),
    .ex_valid_in(ex_valid), .ex_ready_out(ex_ready),
    .ex_is_load_in(ex_is_load), .ex_addr_in(ex_addr),
    .ex_wr_data_in(ex_wr_data), .ex_rd_idx_in(ex_rd_idx),
    .dm_req_out(dm_req), .dm_we_out(dm_we), .dm_addr_out(dm_addr),
    .dm_wr_data_out(dm_wr_data), .dm_ack_in(dm_ack), .dm_rd_data_in(dm_rd_data),
    .dm_rd_data_out(dm_rd_data_q), .reg_wr_out(reg_wr), .rd_idx_out(rd_idx_q),
    .busy_out(busy), .timeout_err_out(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_held();
    check("rd_data_out", 32'(dm_rd_data_q), 32'(exp_rd_data));
    check("rd_idx_out", 32'(rd_idx_q), 32'(exp_rd_idx));
    check("timeout_err", 32'(timeout_err), 32'(exp_err));
  endtask

  // Idle cycles with stray acks that must be ignored.
  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      ex_valid   = 1'b0;
      dm_ack     = 1'($urandom % 2);
      dm_rd_data = 8'($urandom);
      @(negedge clk);
      check("idle_req", 32'(dm_req), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_ready", 32'(ex_ready), 1);
      check("idle_reg_wr", 32'(reg_wr), 0);
      check_held();
    end
    dm_ack = 1'b0;
  endtask

  // One transaction; memory acks after `delay` wait cycles, never if delay >= TO.
  task automatic do_txn(input bit ld, input logic [7:0] a, input logic [7:0] wd,
                        input logic [2:0] rd, input int unsigned delay,
                        input logic [7:0] mem_byte, input bit hold);
    bit acked;
    int unsigned n_req;
    acked = (delay < TO);
    n_req = acked ? delay + 1 : TO;
    check("start_ready", 32'(ex_ready), 1);
    check("start_busy", 32'(busy), 0);
    ex_valid = 1'b1; ex_is_load = ld; ex_addr = a; ex_wr_data = wd; ex_rd_idx = rd;
    dm_ack = 1'b0;
    @(negedge clk);
    for (int unsigned i = 0; i < n_req; i++) begin
      check("req", 32'(dm_req), 1);
      check("we", 32'(dm_we), 32'(!ld));
      check("addr", 32'(dm_addr), 32'(a));
      check("wr_data", 32'(dm_wr_data), 32'(wd));
      check("req_ready", 32'(ex_ready), 0);
      check("req_busy", 32'(busy), 1);
      check("req_reg_wr", 32'(reg_wr), 0);
      check_held();
      if (hold) begin
        ex_valid = 1'b1; ex_is_load = !ld; ex_addr = ~a; ex_wr_data = ~wd; ex_rd_idx = ~rd;
      end else
        ex_valid = 1'b0;
      dm_ack     = acked && (i == delay);
      dm_rd_data = dm_ack ? mem_byte : 8'($urandom);
      @(negedge clk);
    end
    dm_ack = 1'b0;
    if (acked) begin
      check("done_req", 32'(dm_req), 0);
      check("done_busy", 32'(busy), 1);
      check("done_ready", 32'(ex_ready), 0);
      check("done_reg_wr", 32'(reg_wr), 32'(ld));
      if (ld) begin
        exp_rd_data = mem_byte;
        exp_rd_idx  = rd;
      end
      check_held();
      dm_ack     = 1'($urandom % 2);
      dm_rd_data = 8'($urandom);
      @(negedge clk);
      dm_ack = 1'b0;
    end else
      exp_err = 1'b1;
    ex_valid = 1'b0;
    check("end_req", 32'(dm_req), 0);
    check("end_reg_wr", 32'(reg_wr), 0);
    check("end_ready", 32'(ex_ready), 1);
    check_held();
  endtask

  initial begin
    bit ld;
    logic [7:0] a, wd;
    logic [2:0] rd;
    rst = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_addr = '0; ex_wr_data = '0;
    ex_rd_idx = '0; dm_ack = 1'b0; dm_rd_data = '0;
    #2;
    check("rst_ready", 32'(ex_ready), 0);
    check("rst_req", 32'(dm_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_reg_wr", 32'(reg_wr), 0);
    check_held();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    // Load, immediate ack
    do_txn(1'b1, 8'h10, 8'h00, 3'd3, 0, 8'hA5, 1'b0);
    // Store with three wait cycles; load byte must stay 0xA5
    do_txn(1'b0, 8'h22, 8'h3C, 3'd6, 3, 8'hEE, 1'b0);
    // Ack on the last watchdog cycle
    do_txn(1'b1, 8'h31, 8'h00, 3'd5, TO - 1, 8'h5A, 1'b0);
    idle_cycles(2);
    // Back-pressure: held request is accepted once after the unit returns to IDLE
    do_txn(1'b1, 8'h40, 8'h11, 3'd2, 2, 8'h77, 1'b1);
    do_txn(1'b0, 8'hBF, 8'hEE, 3'd5, 1, 8'h00, 1'b0);
    idle_cycles(3);
    // Watchdog: never acked, then next request still accepted
    do_txn(1'b0, 8'h55, 8'h66, 3'd1, TO + 3, 8'h00, 1'b0);
    do_txn(1'b1, 8'h56, 8'h00, 3'd7, 1, 8'hC3, 1'b0);

    for (int unsigned t = 0; t < 40; t++) begin
      ld = 1'($urandom % 2); a = 8'($urandom); wd = 8'($urandom); rd = 3'($urandom);
      do_txn(ld, a, wd, rd, $urandom_range(0, TO + 1), 8'($urandom), ($urandom % 4) == 0);
      idle_cycles($urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of REQ
    do_txn(1'b1, 8'h08, 8'h00, 3'd4, 0, 8'h9D, 1'b0);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_addr = 8'h77; ex_rd_idx = 3'd2;
    @(negedge clk);
    ex_valid = 1'b0;
    check("mid_req", 32'(dm_req), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_rd_data = 8'h00; exp_rd_idx = 3'd0; exp_err = 1'b0;
    check("arst_req", 32'(dm_req), 0);
    check("arst_reg_wr", 32'(reg_wr), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ready", 32'(ex_ready), 0);
    check("arst_addr", 32'(dm_addr), 0);
    check_held();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(ex_ready), 1);
    check("post_rst_busy", 32'(busy), 0);
    @(negedge clk);
    do_txn(1'b1, 8'hE0, 8'h00, 3'd6, 2, 8'h3B, 1'b0);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
